// File: rtl/adaptive_filter_mode_ctrl.sv
// ============================================================================
//  Module   : adaptive_filter_mode_ctrl
//  Purpose  : Sequences filter mode switches (flush with zeros, reset, apply
//             new mode) and forwards filter output with tail marking.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module adaptive_filter_mode_ctrl #(
   parameter int FLUSH_LEN  = 4,
   parameter int RST_CYCLES = 2,
   parameter bit INIT_MODE  = 1'b0
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        mode_req_valid,
   input  logic        mode_req,
   output logic        mode_req_ready,
   input  logic [13:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   output logic [13:0] f_tdata,
   output logic        f_tvalid,
   output logic        f_ctrl,
   output logic        f_srst,
   input  logic [13:0] f_m_tdata,
   input  logic        f_m_tvalid,
   output logic [13:0] m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   output logic        mode_cur,
   output logic        busy,
   output logic [7:0]  switch_cnt
);

   localparam logic [1:0] c_ST_RUN   = 2'd0;
   localparam logic [1:0] c_ST_FLUSH = 2'd1;
   localparam logic [1:0] c_ST_RESET = 2'd2;

   localparam bit         c_HAS_FLUSH = (FLUSH_LEN != 0);
   localparam logic [7:0] c_FLUSH_LD  = c_HAS_FLUSH ? 8'(FLUSH_LEN - 1) : 8'd0;
   localparam logic [3:0] c_RST_LD    = 4'(RST_CYCLES - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [7:0]  r_flush_cnt;
   logic [3:0]  r_rst_cnt;
   logic        r_mode_cur;
   logic        r_mode_tgt;
   logic [7:0]  r_switch_cnt;
   logic        r_flush_d1;
   logic        r_last_d1;
   logic [13:0] r_m_tdata;
   logic        r_m_tvalid;
   logic        r_m_tlast;

   logic        w_req_fire;
   logic        w_switch;
   logic        w_flush_last;
   logic        w_rst_last;

   assign w_req_fire   = mode_req_valid & mode_req_ready;
   assign w_switch     = w_req_fire & (mode_req != r_mode_cur);
   assign w_flush_last = (r_state == c_ST_FLUSH) && (r_flush_cnt == 8'd0);
   assign w_rst_last   = (r_state == c_ST_RESET) && (r_rst_cnt == 4'd0);

   // State register
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state <= c_ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_RUN: begin
            if (w_switch) begin
               w_state_nxt = c_HAS_FLUSH ? c_ST_FLUSH : c_ST_RESET;
            end
         end
         c_ST_FLUSH: begin
            if (w_flush_last) begin
               w_state_nxt = c_ST_RESET;
            end
         end
         c_ST_RESET: begin
            if (w_rst_last) begin
               w_state_nxt = c_ST_RUN;
            end
         end
         default: w_state_nxt = c_ST_RUN;
      endcase
   end

   // Output logic
   always_comb begin
      s_tready       = 1'b0;
      mode_req_ready = 1'b0;
      f_tvalid       = 1'b0;
      f_tdata        = 14'd0;
      case (r_state)
         c_ST_RUN: begin
            s_tready       = 1'b1;
            mode_req_ready = 1'b1;
            f_tvalid       = s_tvalid;
            f_tdata        = s_tdata;
         end
         c_ST_FLUSH: begin
            f_tvalid = 1'b1;
         end
         default: begin
            f_tvalid = 1'b0;
         end
      endcase
   end

   assign f_srst = srst | (r_state == c_ST_RESET);
   assign busy   = (r_state != c_ST_RUN);
   assign f_ctrl = r_mode_cur;

   // Mode and cycle counters; the new mode goes live on the first RESET cycle.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_flush_cnt  <= 8'd0;
         r_rst_cnt    <= 4'd0;
         r_mode_cur   <= INIT_MODE;
         r_mode_tgt   <= INIT_MODE;
         r_switch_cnt <= 8'd0;
      end else begin
         case (r_state)
            c_ST_RUN: begin
               if (w_switch) begin
                  r_mode_tgt  <= mode_req;
                  r_flush_cnt <= c_FLUSH_LD;
                  r_rst_cnt   <= c_RST_LD;
                  if (!c_HAS_FLUSH) begin
                     r_mode_cur <= mode_req;
                  end
               end
            end
            c_ST_FLUSH: begin
               if (r_flush_cnt != 8'd0) begin
                  r_flush_cnt <= r_flush_cnt - 8'd1;
               end else begin
                  r_mode_cur <= r_mode_tgt;
               end
            end
            c_ST_RESET: begin
               if (r_rst_cnt != 4'd0) begin
                  r_rst_cnt <= r_rst_cnt - 4'd1;
               end else begin
                  r_switch_cnt <= r_switch_cnt + 8'd1;
               end
            end
            default: begin
               r_flush_cnt <= 8'd0;
            end
         endcase
      end
   end

   // Flush flags lag one cycle to line up with the filter's output latency.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_flush_d1 <= 1'b0;
         r_last_d1  <= 1'b0;
         r_m_tdata  <= 14'd0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end else begin
         r_flush_d1 <= (r_state == c_ST_FLUSH);
         r_last_d1  <= w_flush_last;
         r_m_tvalid <= f_m_tvalid;
         r_m_tlast  <= f_m_tvalid & r_flush_d1 & r_last_d1;
         if (f_m_tvalid) begin
            r_m_tdata <= f_m_tdata;
         end
      end
   end

   assign m_tdata    = r_m_tdata;
   assign m_tvalid   = r_m_tvalid;
   assign m_tlast    = r_m_tlast;
   assign mode_cur   = r_mode_cur;
   assign switch_cnt = r_switch_cnt;

endmodule

`default_nettype wire
